// File: rtl/dir_pkg.sv
// -----------------------------------------------------------------------------
// dir_pkg
// Shared types and constants for the direction command queue.
//   dir_t        : 2-bit direction command (UP, RIGHT, DOWN, LEFT)
//   KEY_*        : ASCII codes of the accepted movement keys
//   is_reversal  : true when two directions point opposite ways
// -----------------------------------------------------------------------------
package dir_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam logic [7:0] KEY_W_LO = 8'h77;
  localparam logic [7:0] KEY_W_UP = 8'h57;
  localparam logic [7:0] KEY_D_LO = 8'h64;
  localparam logic [7:0] KEY_D_UP = 8'h44;
  localparam logic [7:0] KEY_S_LO = 8'h73;
  localparam logic [7:0] KEY_S_UP = 8'h53;
  localparam logic [7:0] KEY_A_LO = 8'h61;
  localparam logic [7:0] KEY_A_UP = 8'h41;

  // Opposite directions differ only in bit 1 with this encoding.
  function automatic logic is_reversal(dir_t a, dir_t b);
    return ((a ^ b) == 2'b10);
  endfunction

endpackage

// File: rtl/dir_cmd_queue_if.sv
// -----------------------------------------------------------------------------
// dir_cmd_queue_if
// Character-in / command-out bundle of the direction command queue.
//   char_valid, char_in : character strobe from the input stage
//   dir_ready           : consumer pops the head command
//   dir_valid, dir_out  : head command (first-word fall-through)
//   fifo_count          : entries held
//   drop_count          : saturating count of rejected characters
//   drop_pulse          : one-cycle pulse per rejected character
// Modports: master = producer/consumer side, slave = the queue.
// -----------------------------------------------------------------------------
interface dir_cmd_queue_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             char_valid;
  logic [7:0]       char_in;
  logic             dir_ready;
  logic             dir_valid;
  logic [1:0]       dir_out;
  logic [CW-1:0]    fifo_count;
  logic [CNT_W-1:0] drop_count;
  logic             drop_pulse;

  modport master (
    output char_valid, char_in, dir_ready,
    input  dir_valid, dir_out, fifo_count, drop_count, drop_pulse
  );

  modport slave (
    input  char_valid, char_in, dir_ready,
    output dir_valid, dir_out, fifo_count, drop_count, drop_pulse
  );
endinterface

// File: rtl/dir_fifo.sv
// -----------------------------------------------------------------------------
// dir_fifo
// DEPTH x 2-bit synchronous FIFO, first-word fall-through read.
//   clk, rst    : clock, synchronous active-high reset
//   push, wdata : write request (caller guarantees not full unless popping)
//   pop, rdata  : read request (caller guarantees not empty), head entry
//   count       : entries held; full / empty flags
// -----------------------------------------------------------------------------
module dir_fifo
  import dir_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  dir_t          wdata,
  input  logic          pop,
  output dir_t          rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  dir_t             mem_q [DEPTH];
  dir_t             mem_d [DEPTH];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DIR_UP;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});

endmodule

// File: rtl/dir_cmd_queue.sv
// -----------------------------------------------------------------------------
// dir_cmd_queue
// Decodes ASCII movement keys (w/a/s/d, either case) into direction commands,
// rejects undecodable characters, and buffers accepted commands for the game
// tick engine, which pops one per move.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dir_cmd_queue_if.slave (char strobe in, command handshake out,
//              fifo_count, drop_count, drop_pulse)
// Build option: define DIR_REVERSAL_FILTER_EN to also reject any command that
// reverses the last accepted direction (180 degree turn).
// -----------------------------------------------------------------------------
module dir_cmd_queue
  import dir_pkg::*;
#(
  parameter int   DEPTH     = 4,
  parameter int   CNT_W     = 8,
  parameter dir_t RESET_DIR = DIR_RIGHT
) (
  input logic           clk,
  input logic           rst,
  dir_cmd_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             dec_valid_s;
  dir_t             dec_dir_s;
  logic             filt_pass_s;
  logic             push_s;
  logic             pop_s;
  logic             reject_s;
  dir_t             head_s;
  logic [CW-1:0]    count_s;
  logic             full_s;
  logic             empty_s;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             drop_pulse_q, drop_pulse_d;

  // Character decode; every non-key character is simply invalid.
  always_comb begin
    dec_valid_s = 1'b0;
    dec_dir_s   = DIR_UP;
    case (bus.char_in)
      KEY_W_LO, KEY_W_UP: begin dec_valid_s = 1'b1; dec_dir_s = DIR_UP;    end
      KEY_D_LO, KEY_D_UP: begin dec_valid_s = 1'b1; dec_dir_s = DIR_RIGHT; end
      KEY_S_LO, KEY_S_UP: begin dec_valid_s = 1'b1; dec_dir_s = DIR_DOWN;  end
      KEY_A_LO, KEY_A_UP: begin dec_valid_s = 1'b1; dec_dir_s = DIR_LEFT;  end
      default:            begin dec_valid_s = 1'b0; dec_dir_s = DIR_UP;    end
    endcase
  end

`ifdef DIR_REVERSAL_FILTER_EN
  dir_t last_dir_q, last_dir_d;

  assign filt_pass_s = !is_reversal(dec_dir_s, last_dir_q);

  // Track the last accepted direction; it outlives FIFO drains.
  always_comb begin
    if (push_s) begin
      last_dir_d = dec_dir_s;
    end else begin
      last_dir_d = last_dir_q;
    end
  end

  // Last-direction register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dir_q <= RESET_DIR;
    end else begin
      last_dir_q <= last_dir_d;
    end
  end
`else
  logic unused_reset_dir_s;
  assign unused_reset_dir_s = ^RESET_DIR;
  assign filt_pass_s        = 1'b1;
`endif

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop_s    = !empty_s && bus.dir_ready;
  assign push_s   = bus.char_valid && dec_valid_s && filt_pass_s && (!full_s || pop_s);
  assign reject_s = bus.char_valid && !push_s;

  dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (dec_dir_s),
    .pop   (pop_s),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Drop accounting: saturating counter plus registered pulse.
  always_comb begin
    drop_pulse_d = reject_s;
    if (reject_s && (drop_count_q != {CNT_W{1'b1}})) begin
      drop_count_d = drop_count_q + CNT_W'(1);
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // Drop registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= {CNT_W{1'b0}};
      drop_pulse_q <= 1'b0;
    end else begin
      drop_count_q <= drop_count_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  assign bus.dir_valid  = !empty_s;
  assign bus.dir_out    = empty_s ? DIR_UP : head_s;
  assign bus.fifo_count = count_s;
  assign bus.drop_count = drop_count_q;
  assign bus.drop_pulse = drop_pulse_q;

endmodule

// File: doc/dir_cmd_queue.md
Name: dir_cmd_queue

Overview:
- Consumes the ASCII direction characters produced by the keyboard/file input stage, one per strobe.
- Decodes them into 2-bit direction commands, filters invalid and illegal inputs, and buffers them in a small FIFO.
- Game-logic tick engine pops one command per move via a valid/ready handshake.
- Sits between the character-input stage and the game state machine.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 8, width of saturating drop counter.
- RESET_DIR, 2'd1, initial last-accepted direction (RIGHT).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- char_valid  in  1  one-cycle strobe, char_in valid
- char_in  in  8  ASCII character
- dir_ready  in  1  consumer accepts head command this cycle
- dir_valid  out  1  FIFO non-empty; dir_out valid
- dir_out  out  2  head direction: 0=UP 1=RIGHT 2=DOWN 3=LEFT
- fifo_count  out  $clog2(DEPTH+1)  entries held
- drop_count  out  CNT_W  saturating count of rejected characters
- drop_pulse  out  1  one-cycle pulse when a character is rejected

Behaviour:
- Reset (sync, active-high, on clk edge with rst=1): FIFO empty, rd/wr pointers 0, dir_valid=0, dir_out=0, fifo_count=0, drop_count=0, drop_pulse=0, last_dir=RESET_DIR. rst overrides all same-cycle pushes and pops; contents discarded mid-operation.
- Decode, combinational on char_in:
  - 'w'/'W' (0x77/0x57) -> UP
  - 'd'/'D' (0x64/0x44) -> RIGHT
  - 's'/'S' (0x73/0x53) -> DOWN
  - 'a'/'A' (0x61/0x41) -> LEFT
  - anything else invalid; ',' and newline included, no special case.
- Push accepted when char_valid & decode valid & filter pass & (not full OR pop this cycle).
  - On accept: write entry, last_dir <= decoded direction.
- Reject when char_valid and push not accepted.
  - drop_pulse=1 next cycle.
  - drop_count increments, saturating at 2^CNT_W-1.
  - last_dir unchanged.
- Pop when dir_valid & dir_ready. dir_ready with dir_valid=0 is ignored.
- Latency: character accepted at edge N -> dir_valid=1 with that direction after edge N (first-word fall-through, head read combinationally from registered storage).
- Simultaneous push+pop:
  - Full: both occur, count unchanged.
  - Empty: push only, pop impossible.
- Pointers wrap modulo DEPTH. fifo_count = DEPTH means full, 0 means empty.
- dir_out is held stable while dir_valid=1 and dir_ready=0.
- Duplicate consecutive directions are accepted (no dedup).

Optional Feature:
- Macro DIR_REVERSAL_FILTER_EN.
- Defined: decoded direction d is rejected (counted as drop) when (d ^ last_dir) == 2'b10, i.e. a 180° reversal of the last accepted command. last_dir survives FIFO drain; only rst resets it.
- Undefined: no reversal check, all decodable characters pass filter; last_dir register optimised away.

Decomposition:
- Shared package dir_pkg:
  - dir_t 2-bit enum (DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT)
  - ASCII key constants
  - function is_reversal(dir_t a, dir_t b)
- Sub-module dir_fifo: generic DEPTH x 2-bit sync FIFO with count/full/empty.
- Decode, filter and drop counter stay in dir_cmd_queue.

Test Plan:
- Reset, then strobe 'w','d','s' with dir_ready=0 -> fifo_count=3, dir_out=UP; pulse ready 3 cycles -> UP, RIGHT, DOWN in order, dir_valid=0 after.
- Strobe 'x', ',', 0x0A -> drop_pulse 3 times, drop_count=3, fifo_count=0.
- Fill 4 entries ('d' x4), strobe 'w' with ready=0 -> drop_count=1; repeat 'w' with dir_ready=1 same cycle -> accepted, count stays 4.
- With DIR_REVERSAL_FILTER_EN: reset (last=RIGHT), strobe 'a' -> dropped; 'w' -> accepted; 's' -> dropped; 'A' -> accepted. Without the macro all four are accepted.
- Preload drop_count near saturation (CNT_W=2 build), 5 invalid chars -> drop_count stays 3.
- Assert rst mid-stream with 2 entries queued and char_valid=1 -> next cycle fifo_count=0, dir_valid=0, drop_count=0, char not enqueued.
